lane_serializer: RTL
====================

// Module: lane_serializer
// PURPOSE
// - Downstream stage of the 4-lane unique-value buffer. Consumes its parallel
//   slot outputs: out_0..out_3 and out_valid_0..out_valid_3.
// - Detects new items per lane and serializes them onto one valid/ready stream.
// - Tags each item with its lane index. Arbitration is round-robin.
// PARAMETERS
// - DATA_W   8   width of lane data and out_data
// - CNT_W    16  width of drop_count (saturating)
// PORTS
// - clk_in        in   1       single clock, all state on rising edge
// - reset_n_in    in   1       asynchronous, active-low reset
// - lane_data_0   in   DATA_W  lane 0 data (lanes 1..3 identical: lane_data_1..3)
// - lane_valid_0  in   1       lane 0 valid (lanes 1..3: lane_valid_1..3)
// - out_data      out  DATA_W  serialized item
// - out_lane      out  2       source lane of out_data
// - out_valid     out  1       item presented
// - out_ready     in   1       consumer accepts when out_valid && out_ready
// - drop_count    out  CNT_W   items lost to overwrite (see CONFIGURATION)
// BEHAVIOUR
// - Interface: one clock, clk_in. Reset reset_n_in is asynchronous and
//   active-low. Assertion clears all state immediately, independent of clk_in.
// - Reset values:
//   - out_data=0, out_lane=0, out_valid=0, drop_count=0.
//   - Per-lane prev_valid=0, prev_data=0, pending=0, hold=0.
//   - rr_ptr=3, so lane 0 wins first.
// - New item on lane i: lane_valid_i=1 and (prev_valid_i=0 or lane_data_i != prev_data_i).
//   - prev_valid_i and prev_data_i register the lane inputs every cycle.
//   - A lane held valid with unchanged data is NOT re-emitted.
// - On new item: hold_i <= lane_data_i and pending_i <= 1, at the same edge.
// - Output register loads when (!out_valid || out_ready) and any pending_i.
//   - Winner: first pending lane after rr_ptr, wrapping 3->0.
//   - Loads out_data<=hold_w, out_lane<=w, out_valid<=1, clears pending_w, rr_ptr<=w.
//   - If load condition holds but nothing is pending: out_valid<=0.
// - Latency: input presented before edge k -> out_valid high after edge k+1
//   (2 cycles, no bypass).
// - Throughput: 1 item/cycle with out_ready=1.
// - Backpressure: while out_valid && !out_ready, out_data and out_lane are held
//   stable and out_valid stays 1.
// - Boundary conditions:
//   - New item on lane i in the same cycle lane i is loaded to the output:
//     pending_i stays 1 with the new hold_i. This is not a drop.
//   - New item on lane i while pending_i=1 and lane i is not loaded that cycle:
//     hold_i is overwritten and the older item is lost; drop event.
//   - Multiple lanes new in one cycle: all captured; drained in round-robin order.
//   - lane_valid_i falling with pending_i=1: the pending item is still emitted.
//   - Reset mid-stream: pending items and the output item are discarded.
//     No stale item appears after release.
// CONFIGURATION
// - Macro LANE_SERIALIZER_DROP_COUNT_EN.
//   - Defined: drop_count increments by the number of drop events per cycle
//     (0..4) and saturates at 2^CNT_W-1.
//   - Undefined: no counter logic; drop_count is tied to 0. Port list unchanged.
// TESTING
// - Single item: lane_valid_0 0->1 with lane_data_0=0x5A, out_ready=1
//   -> one beat 0x5A, lane 0, 2 cycles later; no repeat while the lane is held.
// - Burst: all lanes new in one cycle with 0x11/0x22/0x33/0x44, out_ready=1
//   -> beats lane0..lane3 on 4 consecutive cycles.
// - Backpressure: 2 items pending, out_ready=0 for 5 cycles
//   -> out_valid=1 with stable data and lane; both drain after ready returns.
// - Overwrite: out_ready=0 with the output full; lane 1 new 0xAA, then 0xBB
//   -> after ready, 0xBB is emitted and 0xAA never is; drop_count=1 (0 if
//   macro undefined).
// - Fairness: lanes 0 and 2 present new data every cycle, out_ready=1
//   -> out_lane alternates 0,2,0,2; no lane starves.
// - Reset: assert reset_n_in=0 mid-burst between edges
//   -> out_valid=0 immediately; after release no beats until fresh new items.

Source files
------------

// File: rtl/lane_serializer.sv
// -----------------------------------------------------------------------------
// lane_serializer
//
// Purpose:
//   Sits downstream of the 4-lane unique-value buffer. Watches the four
//   parallel slot outputs, detects when a lane presents a new item (valid and
//   either newly valid or carrying different data than last cycle), captures
//   it into a per-lane holding register, and serializes the captured items
//   onto a single valid/ready stream tagged with the source lane. Lanes are
//   granted round-robin, starting with lane 0 after reset.
//
// Ports:
//   clk_in          in   1       single clock, all state on rising edge
//   reset_n_in      in   1       asynchronous, active-low reset
//   lane_data_0..3  in   DATA_W  per-lane slot data
//   lane_valid_0..3 in   1       per-lane slot valid
//   out_data        out  DATA_W  serialized item
//   out_lane        out  2       source lane of out_data
//   out_valid       out  1       item presented
//   out_ready       in   1       consumer accepts when out_valid && out_ready
//   drop_count      out  CNT_W   saturating count of items lost to overwrite
//
// Configuration:
//   LANE_SERIALIZER_DROP_COUNT_EN
//     defined   : drop_count counts overwrite events (0..4 per cycle) and
//                 saturates at all-ones.
//     undefined : no counter logic; drop_count is tied to zero.
// -----------------------------------------------------------------------------
module lane_serializer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_in,
  input  logic              reset_n_in,
  input  logic [DATA_W-1:0] lane_data_0,
  input  logic [DATA_W-1:0] lane_data_1,
  input  logic [DATA_W-1:0] lane_data_2,
  input  logic [DATA_W-1:0] lane_data_3,
  input  logic              lane_valid_0,
  input  logic              lane_valid_1,
  input  logic              lane_valid_2,
  input  logic              lane_valid_3,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_lane,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  drop_count
);

  // Gather the flat lane ports into arrays so the per-lane logic can loop.
  logic [DATA_W-1:0] laneData [4];
  logic [3:0]        laneValid;

  assign laneData[0] = lane_data_0;
  assign laneData[1] = lane_data_1;
  assign laneData[2] = lane_data_2;
  assign laneData[3] = lane_data_3;
  assign laneValid   = {lane_valid_3, lane_valid_2, lane_valid_1, lane_valid_0};

  // Registered state
  logic [3:0]        prev_valid_q;
  logic [DATA_W-1:0] prev_data_q [4];
  logic [3:0]        pending_q, pending_d;
  logic [DATA_W-1:0] hold_q [4];
  logic [DATA_W-1:0] hold_d [4];
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_lane_q, out_lane_d;
  logic              out_valid_q, out_valid_d;

  // Combinational helpers
  logic [3:0]        newItem;
  logic [1:0]        winner;
  logic              anyPending;
  logic              loadEn;
  logic [3:0]        loaded;

  // A lane only produces an item on a rising valid or a data change; a lane
  // held valid with the same data is the same item and must not repeat.
  always_comb begin
    newItem = '0;
    for (int i = 0; i < 4; i++) begin
      newItem[i] = laneValid[i] &&
                   (!prev_valid_q[i] || (laneData[i] != prev_data_q[i]));
    end
  end

  // Round-robin search: scan the lanes after the last winner, wrapping, and
  // take the first one with a captured item.
  always_comb begin
    logic [1:0] idx;
    winner     = rr_ptr_q;
    anyPending = 1'b0;
    idx        = rr_ptr_q;
    for (int k = 1; k <= 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!anyPending && pending_q[idx]) begin
        winner     = idx;
        anyPending = 1'b1;
      end
    end
  end

  // The output register may take a new item whenever it is empty or its
  // current item is being accepted this cycle.
  assign loadEn = !out_valid_q || out_ready;

  always_comb begin
    loaded = '0;
    if (loadEn && anyPending) begin
      loaded[winner] = 1'b1;
    end
  end

  // Per-lane capture. A new arrival always wins over the clear caused by the
  // lane being loaded, so an item arriving the same cycle its predecessor
  // leaves stays pending rather than being lost.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < 4; i++) begin
      hold_d[i] = hold_q[i];
      if (loaded[i]) begin
        pending_d[i] = 1'b0;
      end
      if (newItem[i]) begin
        pending_d[i] = 1'b1;
        hold_d[i]    = laneData[i];
      end
    end
  end

  // Output stage: hold under backpressure, otherwise load the winner or go
  // idle. out_data/out_lane keep their last value when going idle.
  always_comb begin
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (loadEn) begin
      if (anyPending) begin
        out_data_d  = hold_q[winner];
        out_lane_d  = winner;
        out_valid_d = 1'b1;
        rr_ptr_d    = winner;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // All datapath and control state. rr_ptr resets to 3 so lane 0 is the
  // first lane searched after reset.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      prev_valid_q <= '0;
      pending_q    <= '0;
      rr_ptr_q     <= 2'd3;
      out_data_q   <= '0;
      out_lane_q   <= '0;
      out_valid_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        prev_data_q[i] <= '0;
        hold_q[i]      <= '0;
      end
    end else begin
      prev_valid_q <= laneValid;
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      out_data_q   <= out_data_d;
      out_lane_q   <= out_lane_d;
      out_valid_q  <= out_valid_d;
      for (int i = 0; i < 4; i++) begin
        prev_data_q[i] <= laneData[i];
        hold_q[i]      <= hold_d[i];
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_lane  = out_lane_q;
  assign out_valid = out_valid_q;

`ifdef LANE_SERIALIZER_DROP_COUNT_EN
  logic [3:0]       dropEvt;
  logic [2:0]       dropSum;
  logic [CNT_W:0]   dropSumWide;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  // A drop is an arrival that overwrites a still-pending item which is not
  // leaving through the output this same cycle.
  always_comb begin
    dropSum = '0;
    for (int i = 0; i < 4; i++) begin
      dropEvt[i] = newItem[i] && pending_q[i] && !loaded[i];
      dropSum    = dropSum + {2'b00, dropEvt[i]};
    end
  end

  // One extra bit of headroom detects overflow for saturation.
  always_comb begin
    dropSumWide  = {1'b0, drop_count_q} + (CNT_W+1)'(dropSum);
    drop_count_d = dropSumWide[CNT_W] ? '1 : dropSumWide[CNT_W-1:0];
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;
`else
  assign drop_count = '0;
`endif

endmodule
